cap_sense_scanner: RTL and testbench
====================================

CAP_SENSE_SCANNER -- requirements
Module: cap_sense_scanner

Interface
REQ-001 Parameter NUM_SENSORS, default 9, number of capacitive sensor channels scanned.
REQ-002 Parameter CHARGE_CYCLES, default 64, clock cycles the shared charge line is held high per measurement.
REQ-003 Parameter TIMEOUT, default 16'hFFFF, maximum discharge count before a measurement is abandoned.
REQ-004 Port clock  input  1  single system clock; all state SHALL change only on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port enable  input  1  high = scanning runs continuously; low = stop after the current sensor.
REQ-007 Port capacitive_sensors_in  input  NUM_SENSORS  raw asynchronous sensor pad levels.
REQ-008 Port capacitive_sensors_out  output  1  shared charge drive line.
REQ-009 Port readings  output  32*NUM_SENSORS  one 32-bit slot per sensor; slot i at bits [32i+31:32i].
REQ-010 Port reading_valid  output  NUM_SENSORS  sticky: slot i has been written at least once since reset.
REQ-011 Port scan_done  output  1  one-cycle pulse when sensor NUM_SENSORS-1 is stored.
REQ-012 Port busy  output  1  high in any state other than IDLE.
REQ-013 Port sensor_sel  output  4  index of the sensor currently being measured.

Function
REQ-014 Each bit of capacitive_sensors_in SHALL pass through a 2-flop synchronizer before use; measured counts include this 2-cycle latency.
REQ-015 FSM states SHALL be IDLE, CHARGE, MEASURE and STORE; exactly one state is active per cycle.
REQ-016 IDLE: capacitive_sensors_out=0; enable=1 -> CHARGE on the next cycle.
REQ-017 CHARGE: capacitive_sensors_out=1 for exactly CHARGE_CYCLES cycles, then -> MEASURE; the shared counter is cleared on exit.
REQ-018 MEASURE: capacitive_sensors_out=0; the counter increments each cycle in which synced bit sensor_sel is high.
REQ-019 MEASURE exit: synced bit low -> STORE with flag=0; otherwise counter==TIMEOUT -> STORE with flag=1; if both hold in the same cycle, the low input wins (flag=0).
REQ-020 Slot format: [15:0] = count, [16] = timeout flag, [31:17] = 0.
REQ-021 STORE (1 cycle): write slot sensor_sel, set reading_valid[sensor_sel], advance sensor_sel, wrapping NUM_SENSORS-1 -> 0.
REQ-022 scan_done SHALL pulse high during the STORE cycle in which sensor_sel==NUM_SENSORS-1.
REQ-023 After STORE: enable=1 -> CHARGE; enable=0 -> IDLE. Dropping enable during CHARGE or MEASURE SHALL NOT abort the measurement in progress.
REQ-024 Slots not being written SHALL hold their value; readings SHALL be registered outputs that never show partial counts.
REQ-025 Sensor i (raw) held high for N cycles after MEASURE entry and then low SHALL yield count N+2 (N+2 < TIMEOUT).

Reset
REQ-026 While reset=1: state=IDLE, capacitive_sensors_out=0, readings=0, reading_valid=0, scan_done=0, busy=0, sensor_sel=0, counter=0, synchronizers=0.
REQ-027 Reset asserted in any state, including mid-MEASURE, SHALL discard the measurement in progress without writing any slot.

Structure
REQ-028 State encodings and the slot field positions (count width 16, flag bit 16) SHALL live in the shared cap_sense definitions header used by the processor-side decode.
REQ-029 A single counter SHALL serve both the CHARGE and MEASURE phases; no per-sensor counters.
REQ-030 The synchronizer SHALL be one sub-module, cap_sense_sync, instantiated once per NUM_SENSORS bit.

Verification
REQ-031 Reset mid-MEASURE on sensor 3 -> next cycle readings=0, reading_valid=0, sensor_sel=0, capacitive_sensors_out=0.
REQ-032 CHARGE_CYCLES=4, enable=1; all inputs fall 10 cycles after MEASURE entry -> every slot = 32'h0000000C; scan_done pulses once per 9 stores.
REQ-033 TIMEOUT=16'd20; sensor 5 input held high -> slot 5 = 32'h00010014; the other slots carry flag=0.
REQ-034 Sensor 2 input falls in the same cycle the counter reaches TIMEOUT -> slot 2 flag=0, count=TIMEOUT.
REQ-035 Deassert enable during CHARGE of sensor 7 -> sensor 7 is still stored, then IDLE with busy=0 and sensor_sel=8; reassert -> scanning resumes at sensor 8 and wraps to 0.
REQ-036 Check the CHARGE duration: capacitive_sensors_out high for exactly CHARGE_CYCLES consecutive cycles per measurement, and busy=1 throughout the scan.

Source files
------------

// File: rtl/cap_sense_scanner_pkg.sv
// Shared cap_sense definitions: FSM state encodings and reading-slot field layout,
// also used by the processor-side decode of the readings bus.
package cap_sense_scanner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CHARGE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_STORE   = 2'd3
   } state_t;

   localparam int SLOT_W   = 32;
   localparam int COUNT_W  = 16;
   localparam int FLAG_BIT = 16;

   // Slot layout: [15:0] discharge count, [16] timeout flag, [31:17] zero.
   function automatic logic [SLOT_W-1:0] pack_slot(input logic [COUNT_W-1:0] count,
                                                   input logic                flag);
      return {15'd0, flag, count};
   endfunction

endpackage

// File: rtl/cap_sense_scanner_if.sv
// Sensor-side and reading-side signals of the scanner, grouped with
// master (controller/bench) and slave (scanner) views.
interface cap_sense_scanner_if #(
   parameter int NUM_SENSORS = 9
);
   logic                        enable;
   logic [NUM_SENSORS-1:0]      capacitive_sensors_in;
   logic                        capacitive_sensors_out;
   logic [32*NUM_SENSORS-1:0]   readings;
   logic [NUM_SENSORS-1:0]      reading_valid;
   logic                        scan_done;
   logic                        busy;
   logic [3:0]                  sensor_sel;

   modport master (
      output enable, capacitive_sensors_in,
      input  capacitive_sensors_out, readings, reading_valid, scan_done, busy, sensor_sel
   );

   modport slave (
      input  enable, capacitive_sensors_in,
      output capacitive_sensors_out, readings, reading_valid, scan_done, busy, sensor_sel
   );
endinterface

// File: rtl/cap_sense_sync.sv
// Two-flop synchronizer for one asynchronous sensor pad level.
module cap_sense_sync (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta_r;
   logic q_r;

   // Metastability filter stage followed by the stable output stage.
   always_ff @(posedge clock) begin
      if (reset) begin
         meta_r <= 1'b0;
         q_r    <= 1'b0;
      end else begin
         meta_r <= d;
         q_r    <= meta_r;
      end
   end

   assign q = q_r;
endmodule

// File: rtl/cap_sense_scanner.sv
// Round-robin capacitive sensor scanner: charges the shared line, times each
// sensor's discharge with one shared counter and stores a 32-bit slot per sensor.
module cap_sense_scanner
   import cap_sense_scanner_pkg::*;
#(
   parameter int          NUM_SENSORS   = 9,
   parameter int          CHARGE_CYCLES = 64,
   parameter logic [15:0] TIMEOUT       = 16'hFFFF
) (
   input  logic               clock,
   input  logic               reset,
   cap_sense_scanner_if.slave bus
);
   localparam logic [15:0] CHARGE_LAST = 16'(CHARGE_CYCLES - 1);
   localparam logic [3:0]  SEL_LAST    = 4'(NUM_SENSORS - 1);

   state_t                    state_r, state_nxt_s;
   logic [15:0]               counter_r, counter_nxt_s;
   logic                      flag_r, flag_nxt_s;
   logic [3:0]                sel_r, sel_nxt_s;
   logic                      store_s;
   logic                      charge_r, charge_nxt_s;
   logic                      busy_r, busy_nxt_s;
   logic                      done_r, done_nxt_s;
   logic [32*NUM_SENSORS-1:0] readings_r;
   logic [NUM_SENSORS-1:0]    valid_r;
   logic [NUM_SENSORS-1:0]    synced_s;
   logic                      bit_s;

   for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sync
      cap_sense_sync u_sync (
         .clock (clock),
         .reset (reset),
         .d     (bus.capacitive_sensors_in[i]),
         .q     (synced_s[i])
      );
   end

   assign bit_s = synced_s[sel_r];

   // State, shared counter, selector and registered status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         counter_r <= 16'd0;
         flag_r    <= 1'b0;
         sel_r     <= 4'd0;
         charge_r  <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         counter_r <= counter_nxt_s;
         flag_r    <= flag_nxt_s;
         sel_r     <= sel_nxt_s;
         charge_r  <= charge_nxt_s;
         busy_r    <= busy_nxt_s;
         done_r    <= done_nxt_s;
      end
   end

   // Next-state decode; a low discharge input outranks the timeout.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:    state_nxt_s = bus.enable ? ST_CHARGE : ST_IDLE;
         ST_CHARGE:  state_nxt_s = (counter_r == CHARGE_LAST) ? ST_MEASURE : ST_CHARGE;
         ST_MEASURE: state_nxt_s = (!bit_s || counter_r == TIMEOUT) ? ST_STORE : ST_MEASURE;
         ST_STORE:   state_nxt_s = bus.enable ? ST_CHARGE : ST_IDLE;
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // Counter, flag and selector updates plus next values of registered outputs.
   always_comb begin
      counter_nxt_s = counter_r;
      flag_nxt_s    = flag_r;
      sel_nxt_s     = sel_r;
      store_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            counter_nxt_s = 16'd0;
            flag_nxt_s    = 1'b0;
         end
         ST_CHARGE: begin
            counter_nxt_s = (counter_r == CHARGE_LAST) ? 16'd0 : counter_r + 16'd1;
         end
         ST_MEASURE: begin
            if (!bit_s) begin
               flag_nxt_s = 1'b0;
            end else if (counter_r == TIMEOUT) begin
               flag_nxt_s = 1'b1;
            end else begin
               counter_nxt_s = counter_r + 16'd1;
            end
         end
         ST_STORE: begin
            store_s       = 1'b1;
            counter_nxt_s = 16'd0;
            flag_nxt_s    = 1'b0;
            sel_nxt_s     = (sel_r == SEL_LAST) ? 4'd0 : sel_r + 4'd1;
         end
         default: begin
            counter_nxt_s = 16'd0;
            flag_nxt_s    = 1'b0;
         end
      endcase
      charge_nxt_s = (state_nxt_s == ST_CHARGE);
      busy_nxt_s   = (state_nxt_s != ST_IDLE);
      done_nxt_s   = (state_nxt_s == ST_STORE) && (sel_r == SEL_LAST);
   end

   // Reading slots: only the selected slot changes, and only in STORE.
   always_ff @(posedge clock) begin
      if (reset) begin
         readings_r <= '0;
         valid_r    <= '0;
      end else if (store_s) begin
         readings_r[32*sel_r +: 32] <= pack_slot(counter_r, flag_r);
         valid_r[sel_r]             <= 1'b1;
      end else begin
         readings_r <= readings_r;
         valid_r    <= valid_r;
      end
   end

   assign bus.capacitive_sensors_out = charge_r;
   assign bus.readings               = readings_r;
   assign bus.reading_valid          = valid_r;
   assign bus.scan_done              = done_r;
   assign bus.busy                   = busy_r;
   assign bus.sensor_sel             = sel_r;
endmodule

// File: tb/tb_cap_sense_scanner.sv
// Scoreboard bench for cap_sense_scanner: expected slots are queued when each
// measurement's discharge stimulus is chosen and compared when the slot is stored.
module tb_cap_sense_scanner;
   import cap_sense_scanner_pkg::*;

   localparam int          N  = 9;
   localparam int          CC = 4;
   localparam logic [15:0] TO = 16'd20;

   logic clock = 1'b0;
   logic reset = 1'b1;

   cap_sense_scanner_if #(.NUM_SENSORS(N)) bus ();

   cap_sense_scanner #(.NUM_SENSORS(N), .CHARGE_CYCLES(CC), .TIMEOUT(TO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_slot [N];
   logic [N-1:0] model_valid;
   int          errors = 0;
   int          checks = 0;

   // Input high for n cycles after MEASURE entry gives count n+2; n<0 = never falls.
   function automatic logic [31:0] expect_slot(input int n);
      int c;
      if (n < 0) return {15'd0, 1'b1, TO};
      c = n + 2;
      if (c <= int'(TO)) return {16'd0, c[15:0]};
      return {15'd0, 1'b1, TO};
   endfunction

   function automatic logic [32*N-1:0] model_vec();
      logic [32*N-1:0] v;
      for (int i = 0; i < N; i++) v[32*i +: 32] = model_slot[i];
      return v;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < N; i++) model_slot[i] = 32'd0;
      model_valid = '0;
      sb.delete();
   endtask

   task automatic measure_one(input int n, input bit drop_en);
      int   k, len, sel, dones, busy_bad, nxt;
      exp_t e;
      bus.capacitive_sensors_in = '1;
      for (k = 0; k < 50 && bus.capacitive_sensors_out !== 1'b1; k++) @(negedge clock);
      checks++;
      if (bus.capacitive_sensors_out !== 1'b1) begin
         errors++;
         $display("FAIL charge_start: out=%b want 1 within 50 cycles", bus.capacitive_sensors_out);
         return;
      end
      len = 0;
      busy_bad = 0;
      while (bus.capacitive_sensors_out === 1'b1 && len < 100) begin
         len++;
         if (bus.busy !== 1'b1) busy_bad++;
         if (drop_en && len == 1) bus.enable = 1'b0;
         @(negedge clock);
      end
      checks++;
      if (len != CC) begin
         errors++;
         $display("FAIL charge_len: got %0d cycles want %0d", len, CC);
      end
      sel = int'(bus.sensor_sel);
      sb.push_back('{sel: sel, val: expect_slot(n)});
      if (n == 0) begin
         bus.capacitive_sensors_in = '0;
      end else if (n > 0) begin
         repeat (n) @(posedge clock);
         #1 bus.capacitive_sensors_in = '0;
         @(negedge clock);
      end
      dones = 0;
      for (k = 0; k < 200 && int'(bus.sensor_sel) == sel; k++) begin
         if (bus.busy !== 1'b1) busy_bad++;
         if (bus.scan_done === 1'b1) dones++;
         @(negedge clock);
      end
      e = sb.pop_front();
      checks++;
      if (int'(bus.sensor_sel) == sel) begin
         errors++;
         $display("FAIL store_wait: sensor_sel stuck at %0d after 200 cycles", sel);
         return;
      end
      model_slot[e.sel]  = e.val;
      model_valid[e.sel] = 1'b1;
      checks++;
      if (bus.readings[32*e.sel +: 32] !== e.val) begin
         errors++;
         $display("FAIL slot%0d: got %h want %h", e.sel, bus.readings[32*e.sel +: 32], e.val);
      end
      checks++;
      if (bus.readings !== model_vec()) begin
         errors++;
         $display("FAIL slots_hold: got %h want %h", bus.readings, model_vec());
      end
      checks++;
      if (bus.reading_valid !== model_valid) begin
         errors++;
         $display("FAIL valid: got %b want %b", bus.reading_valid, model_valid);
      end
      nxt = (sel + 1) % N;
      checks++;
      if (int'(bus.sensor_sel) != nxt) begin
         errors++;
         $display("FAIL sel_advance: got %0d want %0d", bus.sensor_sel, nxt);
      end
      checks++;
      if (dones != ((sel == N-1) ? 1 : 0)) begin
         errors++;
         $display("FAIL scan_done: got %0d pulses want %0d (sensor %0d)", dones, (sel == N-1) ? 1 : 0, sel);
      end
      checks++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL busy_scan: %0d cycles with busy low, want 0", busy_bad);
      end
      if (drop_en) begin
         checks++;
         if (bus.busy !== 1'b0 || bus.capacitive_sensors_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_drop: busy=%b out=%b want 0 0", bus.busy, bus.capacitive_sensors_out);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.enable = 1'b0;
      bus.capacitive_sensors_in = '0;
      clear_model();
      repeat (3) @(negedge clock);
      checks++;
      if (bus.readings !== '0 || bus.reading_valid !== '0) begin
         errors++;
         $display("FAIL reset_slots: readings=%h valid=%b want 0", bus.readings, bus.reading_valid);
      end
      checks++;
      if (bus.sensor_sel !== 4'd0 || bus.capacitive_sensors_out !== 1'b0 ||
          bus.busy !== 1'b0 || bus.scan_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: sel=%0d out=%b busy=%b done=%b want 0 0 0 0",
                  bus.sensor_sel, bus.capacitive_sensors_out, bus.busy, bus.scan_done);
      end
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (bus.busy !== 1'b0 || bus.capacitive_sensors_out !== 1'b0) begin
         errors++;
         $display("FAIL idle_disabled: busy=%b out=%b want 0 0", bus.busy, bus.capacitive_sensors_out);
      end
   endtask

   task automatic test_full_scan();
      logic [32*N-1:0] all_c;
      bus.enable = 1'b1;
      for (int i = 0; i < N; i++) measure_one(10, 1'b0);
      all_c = {N{32'h0000000C}};
      checks++;
      if (bus.readings !== all_c) begin
         errors++;
         $display("FAIL full_scan: got %h want %h", bus.readings, all_c);
      end
   endtask

   task automatic test_timeout();
      int tbl[N] = '{3, 0, 18, 7, 1, -1, 12, 5, 9};
      bus.enable = 1'b1;
      for (int i = 0; i < N; i++) measure_one(tbl[i], 1'b0);
      checks++;
      if (bus.readings[32*5 +: 32] !== 32'h00010014) begin
         errors++;
         $display("FAIL timeout_slot5: got %h want 00010014", bus.readings[32*5 +: 32]);
      end
      checks++;
      if (bus.readings[32*2 +: 32] !== 32'h00000014) begin
         errors++;
         $display("FAIL tie_slot2: got %h want 00000014", bus.readings[32*2 +: 32]);
      end
   endtask

   task automatic test_enable_drop();
      bus.enable = 1'b1;
      for (int i = 0; i < 7; i++) measure_one(2 + i, 1'b0);
      measure_one(6, 1'b1);
      repeat (5) @(negedge clock);
      checks++;
      if (bus.busy !== 1'b0 || bus.sensor_sel !== 4'd8 || bus.capacitive_sensors_out !== 1'b0) begin
         errors++;
         $display("FAIL parked: busy=%b sel=%0d out=%b want 0 8 0",
                  bus.busy, bus.sensor_sel, bus.capacitive_sensors_out);
      end
      bus.enable = 1'b1;
      measure_one(4, 1'b0);
      measure_one(1, 1'b0);
   endtask

   task automatic test_reset_mid_measure();
      int k;
      bus.enable = 1'b1;
      measure_one(2, 1'b0);
      measure_one(3, 1'b0);
      bus.capacitive_sensors_in = '1;
      for (k = 0; k < 50 && bus.capacitive_sensors_out !== 1'b1; k++) @(negedge clock);
      for (k = 0; k < 50 && bus.capacitive_sensors_out !== 1'b0; k++) @(negedge clock);
      @(negedge clock);
      checks++;
      if (bus.sensor_sel !== 4'd3 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: sel=%0d busy=%b want 3 1", bus.sensor_sel, bus.busy);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.readings !== '0 || bus.reading_valid !== '0) begin
         errors++;
         $display("FAIL mid_reset_slots: readings=%h valid=%b want 0", bus.readings, bus.reading_valid);
      end
      checks++;
      if (bus.sensor_sel !== 4'd0 || bus.capacitive_sensors_out !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_ctrl: sel=%0d out=%b busy=%b want 0 0 0",
                  bus.sensor_sel, bus.capacitive_sensors_out, bus.busy);
      end
      bus.enable = 1'b0;
      clear_model();
      @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      checks++;
      if (bus.readings !== '0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: readings=%h busy=%b want 0 0", bus.readings, bus.busy);
      end
      bus.enable = 1'b1;
      measure_one(4, 1'b0);
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.capacitive_sensors_in = '0;
      test_reset();
      test_full_scan();
      test_timeout();
      test_enable_drop();
      test_reset_mid_measure();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
